cim_seq_lif: RTL and testbench

CIM_SEQ_LIF -- requirements
Module: cim_seq_lif

---
 rtl/cim_seq_lif.sv | 176 +++++++++++++++++
 tb/tb_cim_seq_lif.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_seq_lif.sv
// Timestep sequencer for a compute-in-memory macro: drives the DAC/CIM/ADC handshake,
// then integrates each bitline result into a leaky integrate-and-fire membrane.
module cim_seq_lif #(
    parameter int unsigned NUM_INPUTS     = 49,
    parameter int unsigned NUM_OUTPUTS    = 10,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           step_valid,
    output logic                           step_ready,
    input  logic [NUM_INPUTS-1:0]          step_spikes,
    input  logic [15:0]                    threshold,
    input  logic [3:0]                     leak_shift,
    input  logic                           clear_mem,
    output logic [NUM_INPUTS-1:0]          wl_spike,
    output logic                           dac_valid,
    input  logic                           dac_ready,
    output logic                           cim_start,
    input  logic                           cim_done,
    output logic                           adc_start,
    input  logic                           adc_done,
    output logic [$clog2(NUM_OUTPUTS)-1:0] bl_sel,
    input  logic [7:0]                     bl_data,
    output logic [NUM_OUTPUTS-1:0]         out_spikes,
    output logic                           out_valid,
    output logic                           busy,
    output logic                           err_timeout,
    input  logic [$clog2(NUM_OUTPUTS)-1:0] mem_rd_idx,
    output logic [15:0]                    mem_rd_data
);
    localparam int unsigned SW = $clog2(NUM_OUTPUTS);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] LAST_SEL  = SW'(NUM_OUTPUTS - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StDac, StCimGo, StCimWait, StAdcGo, StAdcWait, StRead, StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [TW-1:0]           timer_q;
    logic [15:0]             thr_q;
    logic [3:0]              shift_q;
    logic [SW-1:0]           bl_sel_q;
    logic [NUM_OUTPUTS-1:0]  spike_acc_q, spike_next;
    logic [NUM_OUTPUTS-1:0]  out_spikes_q;
    logic [NUM_INPUTS-1:0]   wl_q;
    logic                    err_q;
    logic [15:0]             mem_q [NUM_OUTPUTS];

    logic        accept, timeout;
    logic [15:0] v, leak, sum_sat;
    logic [16:0] sum17;
    logic        fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        step_ready = 1'b0;
        dac_valid  = 1'b0;
        cim_start  = 1'b0;
        adc_start  = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        timeout    = 1'b0;
        unique case (state_q)
            StIdle: begin
                step_ready = !clear_mem;
                if (step_valid && !clear_mem) begin
                    accept  = 1'b1;
                    state_d = StDac;
                end
            end
            StDac: begin
                dac_valid = 1'b1;
                if (dac_ready) state_d = StCimGo;
            end
            StCimGo: begin
                cim_start = 1'b1;
                state_d   = StCimWait;
            end
            StCimWait: begin
                if (cim_done) begin
                    state_d = StAdcGo;
                end else if (timer_q == LAST_TICK) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end
            end
            StAdcGo: begin
                adc_start = 1'b1;
                state_d   = StAdcWait;
            end
            StAdcWait: begin
                if (adc_done) begin
                    state_d = StRead;
                end else if (timer_q == LAST_TICK) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end
            end
            StRead: begin
                if (bl_sel_q == LAST_SEL) state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Neuron update for the currently selected bitline; leak never exceeds v, so no underflow.
    always_comb begin
        v       = mem_q[bl_sel_q];
        leak    = (shift_q == 4'd0) ? 16'd0 : (v >> shift_q);
        sum17   = {1'b0, v - leak} + {9'd0, bl_data};
        sum_sat = sum17[16] ? 16'hFFFF : sum17[15:0];
        fire    = (sum_sat >= thr_q);
        spike_next           = spike_acc_q;
        spike_next[bl_sel_q] = fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q      <= '0;
            thr_q        <= '0;
            shift_q      <= '0;
            bl_sel_q     <= '0;
            spike_acc_q  <= '0;
            out_spikes_q <= '0;
            wl_q         <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < NUM_OUTPUTS; i++) mem_q[i] <= '0;
        end else begin
            if (state_q == StCimGo || state_q == StAdcGo) begin
                timer_q <= '0;
            end else if (state_q == StCimWait || state_q == StAdcWait) begin
                timer_q <= timer_q + 1'b1;
            end
            if (accept) begin
                wl_q    <= step_spikes;
                thr_q   <= threshold;
                shift_q <= leak_shift;
            end
            if (timeout) err_q <= 1'b1;
            if (state_q == StIdle && clear_mem) begin
                err_q <= 1'b0;
                for (int i = 0; i < NUM_OUTPUTS; i++) mem_q[i] <= '0;
            end
            if (state_q == StRead) begin
                mem_q[bl_sel_q] <= fire ? 16'd0 : sum_sat;
                spike_acc_q     <= spike_next;
                if (bl_sel_q == LAST_SEL) begin
                    bl_sel_q     <= '0;
                    out_spikes_q <= spike_next;  // valid alongside out_valid in DONE
                end else begin
                    bl_sel_q <= bl_sel_q + 1'b1;
                end
            end
        end
    end

    assign wl_spike    = wl_q;
    assign bl_sel      = bl_sel_q;
    assign out_spikes  = out_spikes_q;
    assign busy        = (state_q != StIdle);
    assign err_timeout = err_q;
    assign mem_rd_data = (32'(mem_rd_idx) < NUM_OUTPUTS) ? mem_q[mem_rd_idx] : 16'd0;

endmodule

// File: tb/tb_cim_seq_lif.sv
// Self-checking bench for cim_seq_lif: a timing-randomised macro stub plus an
// arithmetic LIF reference model of membranes and spikes.
module tb_cim_seq_lif;
    localparam int NI = 49;
    localparam int NO = 10;
    localparam int SW = $clog2(NO);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          step_valid = 1'b0;
    logic          step_ready;
    logic [NI-1:0] step_spikes = '0;
    logic [15:0]   threshold = '0;
    logic [3:0]    leak_shift = '0;
    logic          clear_mem = 1'b0;
    logic [NI-1:0] wl_spike;
    logic          dac_valid;
    logic          dac_ready = 1'b0;
    logic          cim_start;
    logic          cim_done = 1'b0;
    logic          adc_start;
    logic          adc_done = 1'b0;
    logic [SW-1:0] bl_sel;
    logic [7:0]    bl_data;
    logic [NO-1:0] out_spikes;
    logic          out_valid;
    logic          busy;
    logic          err_timeout;
    logic [SW-1:0] mem_rd_idx = '0;
    logic [15:0]   mem_rd_data;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    int            ref_mem [NO];
    logic [NO-1:0] ref_out = '0;
    int            bl_pop = 0;
    bit            bl_const = 1'b0;

    always #5 clk = ~clk;

    // Macro model: bitline j returns popcount + 3j, or a constant 255
    always_comb bl_data = bl_const ? 8'd255 : 8'(bl_pop + 3 * int'(bl_sel));

    cim_seq_lif #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst_n(rst_n), .step_valid(step_valid), .step_ready(step_ready),
        .step_spikes(step_spikes), .threshold(threshold), .leak_shift(leak_shift),
        .clear_mem(clear_mem), .wl_spike(wl_spike), .dac_valid(dac_valid),
        .dac_ready(dac_ready), .cim_start(cim_start), .cim_done(cim_done),
        .adc_start(adc_start), .adc_done(adc_done), .bl_sel(bl_sel), .bl_data(bl_data),
        .out_spikes(out_spikes), .out_valid(out_valid), .busy(busy),
        .err_timeout(err_timeout), .mem_rd_idx(mem_rd_idx), .mem_rd_data(mem_rd_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int bl_model(input int j);
        return bl_const ? 255 : bl_pop + 3 * j;
    endfunction

    task automatic model_step(input int thr, input int sh);
        for (int j = 0; j < NO; j++) begin
            int v, s;
            v = ref_mem[j];
            s = v - ((sh == 0) ? 0 : v / (1 << sh)) + bl_model(j);
            if (s > 65535) s = 65535;
            if (s >= thr) begin
                ref_out[j] = 1'b1;
                ref_mem[j] = 0;
            end else begin
                ref_out[j] = 1'b0;
                ref_mem[j] = s;
            end
        end
    endtask

    task automatic model_clear();
        for (int j = 0; j < NO; j++) ref_mem[j] = 0;
    endtask

    task automatic scan_mem(input string tag);
        for (int j = 0; j < NO + 2; j++) begin
            mem_rd_idx = SW'(j);
            #1;
            check($sformatf("%s_mem%0d", tag, j), mem_rd_data, (j < NO) ? ref_mem[j] : 0);
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_mem = 1'b1;
        @(negedge clk);
        clear_mem = 1'b0;
        model_clear();
        check("clear_err", err_timeout, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, step_ready, 1);
        check({tag, "_oval"}, out_valid, 0);
        check({tag, "_ospk"}, out_spikes, 0);
        check({tag, "_wl"}, wl_spike == '0, 1);
        check({tag, "_blsel"}, bl_sel, 0);
        check({tag, "_ctl"}, {dac_valid, cim_start, adc_start}, 0);
        check({tag, "_err"}, err_timeout, 0);
    endtask

    // One timestep. tcim/tadc = wait cycles incl. done (0 = never answer);
    // stall = DAC cycles with dac_ready low; abort_at = cycle at which reset is pulsed.
    task automatic run_step(input logic [NI-1:0] sp, input int thr, input int sh,
                            input int tcim, input int tadc, input int stall,
                            input int abort_at, input bit noise, input string tag);
        int cnt, cpend, apend, stalls_left, exp_cnt;
        bit seen_valid;
        seen_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        bl_pop      = $countones(sp);
        step_spikes = sp;
        threshold   = thr[15:0];
        leak_shift  = sh[3:0];
        step_valid  = 1'b1;
        @(negedge clk);
        step_valid  = 1'b0;
        step_spikes = NI'({$urandom(), $urandom()});
        cnt = 1; cpend = 0; apend = 0; stalls_left = stall;
        while (cnt < 2000) begin
            if (cnt == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs({tag, "_abort"});
                model_clear();
                ref_out = '0;
                {cim_done, adc_done, dac_ready, clear_mem} = '0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            cim_done = 1'b0; adc_done = 1'b0; dac_ready = 1'b0;
            if (cpend > 0) begin cpend--; cim_done = (cpend == 0); end
            if (apend > 0) begin apend--; adc_done = (apend == 0); end
            if (cim_start) cpend = (tcim == 0) ? 100000 : tcim;
            if (adc_start) apend = (tadc == 0) ? 100000 : tadc;
            if (dac_valid) begin
                if (stalls_left > 0) stalls_left--;
                else dac_ready = 1'b1;
                if (noise) begin
                    cim_done = 1'($urandom);
                    adc_done = 1'($urandom);
                end
            end
            clear_mem = (noise && busy) ? 1'($urandom) : 1'b0;
            if (out_valid) begin
                seen_valid = 1'b1;
                break;
            end
            if (!busy) break;
            @(negedge clk);
            cnt++;
        end
        {cim_done, adc_done, dac_ready, clear_mem} = '0;
        if (cnt >= 2000) check({tag, "_bound"}, cnt, 0);
        if (tcim == 0 || tadc == 0) begin
            exp_cnt = (tcim == 0) ? stall + 258 : stall + tcim + 259;
            check({tag, "_tmo_valid"}, seen_valid, 0);
            check({tag, "_tmo_cnt"}, cnt, exp_cnt);
            check({tag, "_tmo_err"}, err_timeout, 1);
            check({tag, "_tmo_ospk"}, out_spikes, ref_out);
        end else begin
            exp_cnt = stall + 4 + tcim + tadc + NO;
            model_step(thr, sh);
            check({tag, "_valid"}, seen_valid, 1);
            check({tag, "_lat"}, cnt, exp_cnt);
            check({tag, "_ospk"}, out_spikes, ref_out);
            check({tag, "_wl"}, wl_spike == sp, 1);
        end
    endtask

    initial begin
        model_clear();
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", step_ready, 1);
        scan_mem("rst");

        // Silent inputs: only the high-offset bitlines cross threshold 20
        run_step('0, 20, 0, 1, 1, 0, -1, 0, "zero");
        check("zero_pattern", out_spikes, 10'b1110000000);
        scan_mem("zero");

        do_clear();
        run_step({NI{1'b1}}, 100, 0, 2, 3, 0, -1, 0, "ones1");
        check("ones1_pattern", out_spikes, 10'b0);
        run_step({NI{1'b1}}, 100, 0, 1, 1, 0, -1, 0, "ones2");
        check("ones2_pattern", out_spikes, 10'b1111111110);
        scan_mem("ones");

        do_clear();
        run_step(NI'(10'h3FF), 16'hFFFF, 1, 1, 2, 1, -1, 0, "leak1");
        mem_rd_idx = '0; #1; check("leak1_m0", mem_rd_data, 10);
        run_step(NI'(10'h3FF), 16'hFFFF, 1, 4, 1, 0, -1, 0, "leak2");
        mem_rd_idx = '0; #1; check("leak2_m0", mem_rd_data, 15);

        do_clear();
        for (int k = 0; k < 25; k++) begin
            run_step(NI'({$urandom(), $urandom()}), $urandom_range(0, 400),
                     $urandom_range(0, 15), $urandom_range(1, 6), $urandom_range(1, 6),
                     $urandom_range(0, 3), -1, 1, "rnd");
        end
        scan_mem("rnd");

        // Macro never answers: error sticks, results untouched
        run_step(NI'({$urandom(), $urandom()}), 50, 2, 0, 1, 0, -1, 0, "tmocim");
        #1; check("tmocim_ready", step_ready, 1);
        scan_mem("tmocim");
        run_step(NI'({$urandom(), $urandom()}), 50, 2, 3, 0, 2, -1, 1, "tmoadc");
        scan_mem("tmoadc");
        do_clear();
        scan_mem("tmoclr");

        // Constant full-scale bitlines: membranes climb to 16'hFFFF on step 257
        bl_const = 1'b1;
        for (int k = 0; k < 257; k++) run_step('0, 16'hFFFF, 0, 1, 1, 0, -1, 0, "sat");
        check("sat_step257", out_spikes, 10'h3FF);
        scan_mem("sat");
        bl_const = 1'b0;

        // Reset pulsed mid-READ, then a step must behave as after cold reset
        run_step({NI{1'b1}}, 30, 0, 2, 2, 0, 12, 0, "abort");
        scan_mem("abort");
        run_step('0, 20, 0, 1, 1, 0, -1, 0, "cold");
        check("cold_pattern", out_spikes, 10'b1110000000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
